// File: rtl/uart_rx_ctrl_if.sv
// CPU-side bus for the UART receive-ring controller: request strobe, write enable, address, write data, read data, ack.
// Latency: request in cycle N is acked in cycle N+2; rdata is valid only while bus_ack is high.
// Backpressure: none; the requester keeps a single access outstanding and waits for bus_ack.
// Ports: bus_req/bus_we/bus_addr/bus_wdata (master -> slave), bus_rdata/bus_ack (slave -> master).
interface uart_rx_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Read-side controller for the UART receive ring: push/overrun tracking, DATA/STATUS/CTRL registers, level irq.
// Latency: bus request in cycle N -> ack in N+2; a push in cycle N shows in count/STATUS/irq from N+1.
// Backpressure: none; requests arriving outside IDLE are ignored, and an overrun drops the oldest byte.
// Ports: clk, rst (sync, active-high), rx_wr_idx (receiver write index), buf_rd_idx/buf_rd_data (ring read port),
//        bus (uart_rx_ctrl_if slave), irq (level interrupt).
// Optional feature: define UART_RX_CTRL_TIMEOUT_EN to build the idle-timeout counter and STATUS bit3.
module uart_rx_ctrl #(
  parameter int BufferSize   = 128,
  parameter int ClockFreqHz  = 10000000,
  parameter int BaudRate     = 115200,
  parameter int TimeoutChars = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(BufferSize)-1:0] rx_wr_idx,
  output logic [$clog2(BufferSize)-1:0] buf_rd_idx,
  input  logic [7:0]                    buf_rd_data,
  uart_rx_ctrl_if.slave                 bus,
  output logic                          irq
);
  localparam int IW = $clog2(BufferSize);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BufferSize - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BufferSize - 1);

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  state_t        state_q;
  logic          we_q;
  logic [3:0]    addr_q;
  logic [15:0]   wdata_q;
  logic          bus_ack_q;
  logic [31:0]   bus_rdata_q;

  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] wr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q;
  logic          rx_ie_q, ovf_ie_q, to_ie_q;
  logic [7:0]    thr_q;

  logic          push, pop, empty, full, overrun, status_wr;
  logic [7:0]    count8;
  logic [31:0]   rd_val;

  // Ring depth need not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + IW'(1);
  endfunction

  assign push      = (rx_wr_idx != wr_q);
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = (state_q == EXEC) && !we_q && (addr_q == ADDR_DATA) && !empty;
  // A same-cycle pop already makes room, so only a push into a full ring without a pop drops data.
  assign overrun   = push && full && !pop;
  assign status_wr = (state_q == EXEC) && we_q && (addr_q == ADDR_STATUS);
  assign count8    = 8'(count_q);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    // Pop and overrun drop share a single advance of the read pointer.
    if (pop || overrun) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop && !full)  count_d = count_q + CW'(1);
    else if (pop && !push)      count_d = count_q - CW'(1);
    if (status_wr && wdata_q[2]) overflow_d = 1'b0;
    // A fresh overrun wins over a same-cycle clear so the event is not lost.
    if (overrun) overflow_d = 1'b1;
  end

  // Read mux samples the registers as they stand at the start of EXEC.
  always_comb begin
    case (addr_q)
      ADDR_DATA:   rd_val = empty ? 32'h0000_0100 : {24'h0, buf_rd_data};
      ADDR_STATUS: rd_val = {16'h0, count8, 4'h0, timeout_q, overflow_q, full, empty};
      ADDR_CTRL:   rd_val = {16'h0, thr_q, 5'h0, to_ie_q, ovf_ie_q, rx_ie_q};
      default:     rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_q       <= rx_wr_idx;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_ack_q   <= 1'b0;
      bus_rdata_q <= '0;
      rx_ie_q     <= 1'b0;
      ovf_ie_q    <= 1'b0;
      to_ie_q     <= 1'b0;
      thr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bus_ack_q <= 1'b0;
          if (bus.bus_req) begin
            we_q    <= bus.bus_we;
            addr_q  <= bus.bus_addr;
            wdata_q <= bus.bus_wdata[15:0];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          bus_rdata_q <= we_q ? 32'h0 : rd_val;
          if (we_q && addr_q == ADDR_CTRL) begin
            rx_ie_q  <= wdata_q[0];
            ovf_ie_q <= wdata_q[1];
            to_ie_q  <= wdata_q[2];
            thr_q    <= wdata_q[15:8];
          end
          bus_ack_q <= 1'b1;
          state_q   <= ACK;
        end
        ACK: begin
          // rdata stays as captured; only the ack strobe drops.
          bus_ack_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          bus_ack_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TO_LIMIT = TimeoutChars * 10 * (ClockFreqHz / BaudRate);
  localparam int TW       = $clog2(TO_LIMIT + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_d;

  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (push || pop)                              to_cnt_d = '0;
    else if (!empty && to_cnt_q != TW'(TO_LIMIT)) to_cnt_d = to_cnt_q + TW'(1);
    if (status_wr && wdata_q[3]) timeout_d = 1'b0;
    // Set only on arrival at the limit; a saturated counter must not re-set a flag the CPU just cleared.
    if (to_cnt_q != TW'(TO_LIMIT) && to_cnt_d == TW'(TO_LIMIT)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  localparam int unused_to_cfg = TimeoutChars + ClockFreqHz + BaudRate;
  logic unused_to_bit;
  assign unused_to_bit = wdata_q[3];
  assign timeout_q     = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.bus_wdata[31:16], wdata_q[7:4]};

  assign buf_rd_idx    = rd_ptr_q;
  assign bus.bus_ack   = bus_ack_q;
  assign bus.bus_rdata = bus_rdata_q;
  assign irq = (rx_ie_q && (thr_q != 8'h0) && (32'(count_q) >= 32'(thr_q)))
             | (ovf_ie_q && overflow_q)
             | (to_ie_q && timeout_q);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int BS = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rx_wr_idx = '0;
  logic [6:0] buf_rd_idx;
  logic [7:0] buf_rd_data;
  logic       irq;
  logic [7:0] mem [0:BS-1];

  uart_rx_ctrl_if bus_if();

  uart_rx_ctrl #(.BufferSize(BS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_wr_idx  (rx_wr_idx),
    .buf_rd_idx (buf_rd_idx),
    .buf_rd_data(buf_rd_data),
    .bus        (bus_if),
    .irq        (irq)
  );

  assign buf_rd_data = mem[buf_rd_idx];

  always #5 clk = ~clk;

  // Scoreboard: bytes expected to come out of DATA, in order.
  logic [7:0] sb[$];
  int  wr_m = 0;
  int  rd_m = 0;
  bit  ovf_m = 1'b0;
  bit  to_m = 1'b0;
  int  checks = 0;
  int  failures = 0;

  function automatic logic [31:0] status_exp();
    int c;
    c = sb.size();
    return {16'h0, 8'(c), 4'h0, to_m, ovf_m, (c == BS - 1), (c == 0)};
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    mem[wr_m] = b;
    wr_m = (wr_m + 1) % BS;
    rx_wr_idx = 7'(wr_m);
    if (sb.size() == BS - 1) begin
      void'(sb.pop_front());
      rd_m = (rd_m + 1) % BS;
      ovf_m = 1'b1;
    end
    sb.push_back(b);
  endtask

  // One bus access; optionally advances the receiver index during the EXEC cycle.
  task automatic bus_access(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                            input bit push_exec, input logic [7:0] pb,
                            output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    bus_if.bus_req   = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wd;
    @(posedge clk); #1;
    bus_if.bus_req = 1'b0;
    if (push_exec) begin
      mem[wr_m] = pb;
      wr_m = (wr_m + 1) % BS;
      rx_wr_idx = 7'(wr_m);
    end
    lat = 1;
    while (bus_if.bus_ack !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus_if.bus_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_if.bus_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", bus_if.bus_ack); end
    checks++; if (bus_if.bus_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", bus_if.bus_rdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (buf_rd_idx !== 7'd0) begin failures++; $display("FAIL reset_rd_idx: got %0d want 0", buf_rd_idx); end
    rst = 1'b0;
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL reset_status_latency: got %0d want 2", lat); end
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL reset_status: got %h want 00000001", d); end
    bus_access(1'b0, 4'h0, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== 32'h100) begin failures++; $display("FAIL empty_data_read: got %h want 00000100", d); end
    checks++; if (buf_rd_idx !== 7'd0) begin failures++; $display("FAIL empty_read_no_pop: got %0d want 0", buf_rd_idx); end
  endtask

  task automatic test_basic_rx();
    logic [31:0] d, e;
    int lat;
    push_byte(8'h41);
    push_byte(8'h42);
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL basic_status_two: got %h want %h", d, e); end
    for (int i = 0; i < 2; i++) begin
      e = {24'h0, sb[0]};
      bus_access(1'b0, 4'h0, 32'h0, 1'b0, 8'h0, d, lat);
      void'(sb.pop_front()); rd_m = (rd_m + 1) % BS;
      checks++; if (d !== e) begin failures++; $display("FAIL basic_data_%0d: got %h want %h", i, d, e); end
    end
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL basic_status_empty: got %h want %h", d, e); end
  endtask

  task automatic test_irq_threshold();
    logic [31:0] d, e;
    int lat;
    bus_access(1'b1, 4'h8, 32'h0000_0201, 1'b0, 8'h0, d, lat);
    push_byte(8'h10);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_below_thr: got %b want 0", irq); end
    push_byte(8'h11);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_same_cycle_as_push: got %b want 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_at_thr: got %b want 1", irq); end
    e = {24'h0, sb[0]};
    bus_access(1'b0, 4'h0, 32'h0, 1'b0, 8'h0, d, lat);
    void'(sb.pop_front()); rd_m = (rd_m + 1) % BS;
    checks++; if (d !== e) begin failures++; $display("FAIL irq_pop_data: got %h want %h", d, e); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_pop: got %b want 0", irq); end
    e = {24'h0, sb[0]};
    bus_access(1'b0, 4'h0, 32'h0, 1'b0, 8'h0, d, lat);
    void'(sb.pop_front()); rd_m = (rd_m + 1) % BS;
    checks++; if (d !== e) begin failures++; $display("FAIL irq_drain_data: got %h want %h", d, e); end
    bus_access(1'b1, 4'h8, 32'h0, 1'b0, 8'h0, d, lat);
  endtask

  task automatic test_overrun();
    logic [31:0] d, e;
    int lat;
    for (int i = 0; i < BS; i++) push_byte(8'(i + 8'h80));
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL overrun_status: got %h want %h", d, e); end
    checks++; if (buf_rd_idx !== 7'(rd_m)) begin failures++; $display("FAIL overrun_rd_idx: got %0d want %0d", buf_rd_idx, rd_m); end
    e = {24'h0, sb[0]};
    bus_access(1'b0, 4'h0, 32'h0, 1'b0, 8'h0, d, lat);
    void'(sb.pop_front()); rd_m = (rd_m + 1) % BS;
    checks++; if (d !== e) begin failures++; $display("FAIL overrun_first_byte: got %h want %h", d, e); end
    bus_access(1'b1, 4'h4, 32'h0000_0004, 1'b0, 8'h0, d, lat);
    ovf_m = 1'b0;
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL overflow_clear: got %h want %h", d, e); end
  endtask

  task automatic test_wrap_push_pop();
    logic [31:0] d, e;
    int lat, guard;
    guard = 0;
    while (rd_m != BS - 1 && sb.size() > 1 && guard < 200) begin
      e = {24'h0, sb[0]};
      bus_access(1'b0, 4'h0, 32'h0, 1'b0, 8'h0, d, lat);
      void'(sb.pop_front()); rd_m = (rd_m + 1) % BS;
      guard++;
      checks++; if (d !== e) begin failures++; $display("FAIL wrap_drain_%0d: got %h want %h", guard, d, e); end
    end
    checks++; if (buf_rd_idx !== 7'(BS - 1)) begin failures++; $display("FAIL wrap_setup_rd_idx: got %0d want %0d", buf_rd_idx, BS - 1); end
    e = {24'h0, sb[0]};
    bus_access(1'b0, 4'h0, 32'h0, 1'b1, 8'hEE, d, lat);
    void'(sb.pop_front()); rd_m = (rd_m + 1) % BS;
    sb.push_back(8'hEE);
    checks++; if (d !== e) begin failures++; $display("FAIL wrap_pop_data: got %h want %h", d, e); end
    checks++; if (buf_rd_idx !== 7'd0) begin failures++; $display("FAIL wrap_rd_idx: got %0d want 0", buf_rd_idx); end
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL wrap_count: got %h want %h", d, e); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d, e;
    int lat;
    bus_access(1'b1, 4'hC, 32'hFFFF_FFFF, 1'b0, 8'h0, d, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL unmapped_write_ack: got latency %0d want 2", lat); end
    bus_access(1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 8'h0, d, lat);
    bus_access(1'b0, 4'hC, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h want 0", d); end
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL data_write_ignored: got %h want %h", d, e); end
  endtask

  task automatic test_timeout();
    logic [31:0] d, e;
    int lat;
    while (sb.size() > 0) begin
      e = {24'h0, sb[0]};
      bus_access(1'b0, 4'h0, 32'h0, 1'b0, 8'h0, d, lat);
      void'(sb.pop_front()); rd_m = (rd_m + 1) % BS;
      checks++; if (d !== e) begin failures++; $display("FAIL to_drain: got %h want %h", d, e); end
    end
    bus_access(1'b1, 4'h8, 32'h0000_0004, 1'b0, 8'h0, d, lat);
    push_byte(8'h55);
    repeat (3000) @(posedge clk);
    push_byte(8'h56);
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL to_not_yet: got %h want %h", d, e); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL to_irq_not_yet: got %b want 0", irq); end
    repeat (3472) @(posedge clk);
    #1;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    to_m = 1'b1;
`endif
    checks++; if (irq !== to_m) begin failures++; $display("FAIL to_irq: got %b want %b", irq, to_m); end
    e = status_exp();
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== e) begin failures++; $display("FAIL to_status: got %h want %h", d, e); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d;
    int lat;
    int acks;
    @(posedge clk); #1;
    bus_if.bus_req  = 1'b1;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_addr = 4'h4;
    @(posedge clk); #1;
    bus_if.bus_req = 1'b0;
    rst = 1'b1;
    rx_wr_idx = '0;
    wr_m = 0; rd_m = 0; ovf_m = 1'b0; to_m = 1'b0;
    sb.delete();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus_if.bus_ack === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL inflight_dropped: got %0d acks want 0", acks); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL inflight_irq: got %b want 0", irq); end
    rst = 1'b0;
    bus_access(1'b0, 4'h8, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", d); end
    bus_access(1'b0, 4'h4, 32'h0, 1'b0, 8'h0, d, lat);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL reset_status_again: got %h want 00000001", d); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < BS; i++) mem[i] = 8'h00;
    bus_if.bus_req   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = 4'h0;
    bus_if.bus_wdata = 32'h0;
    test_reset();
    test_basic_rx();
    test_irq_threshold();
    test_overrun();
    test_wrap_push_pop();
    test_unmapped();
    test_timeout();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
